// File: rtl/tlp_mwr_tx.sv
// PCIe Memory Write TLP builder: turns a 1/2 DW write request into 3DW/4DW header MWr TLP beats
// on the 64-bit AXI4-Stream TX port, with tag sequencing and statistics counters.
module tlp_mwr_tx #(
    parameter logic [7:0]  TAG_INIT  = 8'h00,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 user_clk,
    input  logic                 user_reset,
    input  logic                 user_lnk_up,
    input  logic [15:0]          cfg_completer_id,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [63:0]          req_addr,
    input  logic                 req_len2,
    input  logic [3:0]           req_first_be,
    input  logic [3:0]           req_last_be,
    input  logic [63:0]          req_data,
    input  logic                 s_axis_tx_tready,
    output logic [63:0]          s_axis_tx_tdata,
    output logic [7:0]           s_axis_tx_tkeep,
    output logic                 s_axis_tx_tlast,
    output logic                 s_axis_tx_tvalid,
    output logic                 tx_src_dsc,
    output logic [CNT_WIDTH-1:0] tlp_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        BEAT2 = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [63:0]            tdata_q, tdata_d;
    logic [7:0]             tkeep_q, tkeep_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;
    logic [7:0]             tag_q, tag_d;
    logic                   is4_q, is4_d;
    logic                   len2_q, len2_d;
    logic [31:0]            addr_hi_q, addr_hi_d;
    logic [29:0]            addr_lo_q, addr_lo_d;
    logic [63:0]            data_q, data_d;
    logic [CNT_WIDTH-1:0]   tlp_cnt_q, tlp_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

    logic        accept;
    logic        crosses_4k;
    logic        req_is4;
    logic        handshake;
    logic        go_idle;
    logic [31:0] hdr0;
    logic [31:0] hdr1;
    logic        unused_addr_bits;

    assign req_ready        = (state_q == IDLE) & user_lnk_up & ~user_reset;
    assign accept           = req_valid & req_ready;
    assign req_is4          = (req_addr[63:32] != 32'h0);
    // A 2 DW write starting at the last DW of a 4 KB page would cross the page.
    assign crosses_4k       = req_len2 & (req_addr[11:2] == 10'h3FF);
    assign handshake        = tvalid_q & s_axis_tx_tready;
    assign unused_addr_bits = ^req_addr[1:0];

    assign hdr0 = {1'b0, req_is4 ? 2'b11 : 2'b10, 5'b0, 8'b0, 6'b0,
                   req_len2 ? 10'd2 : 10'd1};
    assign hdr1 = {cfg_completer_id, tag_q, req_len2 ? req_last_be : 4'h0, req_first_be};

    always_comb begin
        state_d    = state_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        tag_d      = tag_q;
        is4_d      = is4_q;
        len2_d     = len2_q;
        addr_hi_d  = addr_hi_q;
        addr_lo_d  = addr_lo_q;
        data_d     = data_q;
        tlp_cnt_d  = tlp_cnt_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        go_idle    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (crosses_4k) begin
                        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        is4_d     = req_is4;
                        len2_d    = req_len2;
                        addr_hi_d = req_addr[63:32];
                        addr_lo_d = req_addr[31:2];
                        data_d    = req_data;
                        state_d   = BEAT0;
                        tvalid_d  = 1'b1;
                        tdata_d   = {hdr1, hdr0};
                        tkeep_d   = 8'hFF;
                        tlast_d   = 1'b0;
                    end
                end
            end
            BEAT0: begin
                if (!user_lnk_up) begin
                    go_idle    = 1'b1;
                    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                end else if (handshake) begin
                    state_d = BEAT1;
                    tkeep_d = 8'hFF;
                    if (is4_q) begin
                        tdata_d = {addr_lo_q, 2'b00, addr_hi_q};
                        tlast_d = 1'b0;
                    end else begin
                        tdata_d = {data_q[31:0], addr_lo_q, 2'b00};
                        tlast_d = ~len2_q;
                    end
                end
            end
            BEAT1: begin
                if (!user_lnk_up) begin
                    go_idle    = 1'b1;
                    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                end else if (handshake) begin
                    if (tlast_q) begin
                        go_idle   = 1'b1;
                        tag_d     = tag_q + 8'd1;
                        tlp_cnt_d = tlp_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        // Third beat carries whatever payload DWs the header beats did not.
                        state_d = BEAT2;
                        tlast_d = 1'b1;
                        if (is4_q && len2_q) begin
                            tdata_d = data_q;
                            tkeep_d = 8'hFF;
                        end else if (is4_q) begin
                            tdata_d = {32'h0, data_q[31:0]};
                            tkeep_d = 8'h0F;
                        end else begin
                            tdata_d = {32'h0, data_q[63:32]};
                            tkeep_d = 8'h0F;
                        end
                    end
                end
            end
            BEAT2: begin
                if (!user_lnk_up) begin
                    go_idle    = 1'b1;
                    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                end else if (handshake) begin
                    go_idle   = 1'b1;
                    tag_d     = tag_q + 8'd1;
                    tlp_cnt_d = tlp_cnt_q + CNT_WIDTH'(1);
                end
            end
        endcase

        if (go_idle) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = 64'h0;
            tkeep_d  = 8'h00;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q    <= IDLE;
            tdata_q    <= 64'h0;
            tkeep_q    <= 8'h00;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            tag_q      <= TAG_INIT;
            is4_q      <= 1'b0;
            len2_q     <= 1'b0;
            addr_hi_q  <= 32'h0;
            addr_lo_q  <= 30'h0;
            data_q     <= 64'h0;
            tlp_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            tag_q      <= tag_d;
            is4_q      <= is4_d;
            len2_q     <= len2_d;
            addr_hi_q  <= addr_hi_d;
            addr_lo_q  <= addr_lo_d;
            data_q     <= data_d;
            tlp_cnt_q  <= tlp_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign s_axis_tx_tdata  = tdata_q;
    assign s_axis_tx_tkeep  = tkeep_q;
    assign s_axis_tx_tlast  = tlast_q;
    assign s_axis_tx_tvalid = tvalid_q;
    assign tx_src_dsc       = 1'b0;
    assign tlp_count        = tlp_cnt_q;
    assign err_count        = err_cnt_q;
    assign drop_count       = drop_cnt_q;

endmodule

// File: tb/tb_tlp_mwr_tx.sv
// Bench for tlp_mwr_tx: directed and random write requests; expected beats are queued at acceptance
// and compared by an independent monitor on every TX handshake.
module tb_tlp_mwr_tx;

    localparam int unsigned CW = 32;

    logic           user_clk = 1'b0;
    logic           user_reset;
    logic           user_lnk_up;
    logic [15:0]    cfg_completer_id;
    logic           req_valid;
    logic           req_ready;
    logic [63:0]    req_addr;
    logic           req_len2;
    logic [3:0]     req_first_be;
    logic [3:0]     req_last_be;
    logic [63:0]    req_data;
    logic           s_axis_tx_tready;
    logic [63:0]    s_axis_tx_tdata;
    logic [7:0]     s_axis_tx_tkeep;
    logic           s_axis_tx_tlast;
    logic           s_axis_tx_tvalid;
    logic           tx_src_dsc;
    logic [CW-1:0]  tlp_count;
    logic [CW-1:0]  err_count;
    logic [CW-1:0]  drop_count;

    always #5 user_clk = ~user_clk;

    tlp_mwr_tx #(.TAG_INIT(8'h00), .CNT_WIDTH(CW)) dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .user_lnk_up      (user_lnk_up),
        .cfg_completer_id (cfg_completer_id),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_len2         (req_len2),
        .req_first_be     (req_first_be),
        .req_last_be      (req_last_be),
        .req_data         (req_data),
        .s_axis_tx_tready (s_axis_tx_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .tx_src_dsc       (tx_src_dsc),
        .tlp_count        (tlp_count),
        .err_count        (err_count),
        .drop_count       (drop_count)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  mtag    = 8'h00;
    int          mtlp    = 0;
    int          merr    = 0;
    int          mdrop   = 0;
    bit          rand_bp = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: list the TLP's DWs in order, then pack them two per beat, low DW first.
    function automatic void model_push(input logic [63:0] addr, input logic len2,
                                       input logic [3:0] fbe, input logic [3:0] lbe,
                                       input logic [63:0] data, input int keep);
        logic [31:0] dw[$];
        beat_t       b;
        logic        is4;
        int          kept;
        kept = 0;
        if (len2 && addr[11:2] == 10'h3FF) begin
            merr++;
            return;
        end
        is4 = (addr[63:32] != 32'h0);
        dw.push_back({1'b0, is4 ? 2'b11 : 2'b10, 5'b0, 8'b0, 6'b0, len2 ? 10'd2 : 10'd1});
        dw.push_back({cfg_completer_id, mtag, len2 ? lbe : 4'h0, fbe});
        if (is4) dw.push_back(addr[63:32]);
        dw.push_back({addr[31:2], 2'b00});
        dw.push_back(data[31:0]);
        if (len2) dw.push_back(data[63:32]);
        for (int i = 0; i < dw.size(); i += 2) begin
            b.d = {(i + 1 < dw.size()) ? dw[i+1] : 32'h0, dw[i]};
            b.k = (i + 1 < dw.size()) ? 8'hFF : 8'h0F;
            b.l = (i + 2 >= dw.size());
            if (keep < 0 || kept < keep) begin
                exp_q.push_back(b);
                kept++;
            end
        end
        if (keep < 0) begin
            mtag = mtag + 8'd1;
            mtlp++;
        end
    endfunction

    task automatic drive_req(input logic [63:0] addr, input logic len2, input logic [3:0] fbe,
                             input logic [3:0] lbe, input logic [63:0] data);
        req_addr     = addr;
        req_len2     = len2;
        req_first_be = fbe;
        req_last_be  = lbe;
        req_data     = data;
        req_valid    = 1'b1;
    endtask

    // Returns one time step after the accepting edge, i.e. while B0 is being presented.
    task automatic wait_accept(output bit ok);
        bit acc;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge user_clk);
            acc = req_ready;
            @(posedge user_clk);
            #1;
            if (acc) begin
                req_valid = 1'b0;
                ok = 1'b1;
                return;
            end
        end
        req_valid = 1'b0;
        chk("accept_timeout", 128'(acc), 128'(1));
    endtask

    task automatic send(input logic [63:0] addr, input logic len2, input logic [3:0] fbe,
                        input logic [3:0] lbe, input logic [63:0] data, input int keep,
                        input bit use_model);
        bit ok;
        drive_req(addr, len2, fbe, lbe, data);
        wait_accept(ok);
        if (ok && use_model) model_push(addr, len2, fbe, lbe, data, keep);
    endtask

    task automatic drain();
        for (int c = 0; c < 3000; c++) begin
            @(negedge user_clk);
            if (exp_q.size() == 0 && !s_axis_tx_tvalid) begin
                @(posedge user_clk);
                #1;
                return;
            end
        end
        chk("drain_timeout", 128'(exp_q.size()), 128'(0));
        @(posedge user_clk);
        #1;
    endtask

    // Monitor: pops one expected beat per handshake and checks that stalled beats are held.
    logic        prev_ok = 1'b0;
    logic [72:0] prev_beat;
    always @(negedge user_clk) begin
        beat_t e;
        if (!user_reset && s_axis_tx_tvalid && s_axis_tx_tready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_beat: got %0h expected no beat", s_axis_tx_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("beat", 128'({s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast}), 128'(e));
            end
        end
        if (prev_ok)
            chk("hold", 128'({s_axis_tx_tvalid, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast}),
                128'({1'b1, prev_beat}));
        prev_ok   = s_axis_tx_tvalid && !s_axis_tx_tready && user_lnk_up && !user_reset;
        prev_beat = {s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast};
    end

    always @(posedge user_clk) begin
        if (rand_bp) begin
            #1;
            s_axis_tx_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        bit          ok;
        logic [31:0] hi;
        logic [31:0] lo;
        user_reset       = 1'b1;
        user_lnk_up      = 1'b1;
        cfg_completer_id = 16'h0100;
        req_valid        = 1'b0;
        req_addr         = 64'h0;
        req_len2         = 1'b0;
        req_first_be     = 4'h0;
        req_last_be      = 4'h0;
        req_data         = 64'h0;
        s_axis_tx_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        chk("rst_tvalid", 128'(s_axis_tx_tvalid), 128'(0));
        chk("rst_tdata", 128'(s_axis_tx_tdata), 128'(0));
        chk("rst_tkeep_tlast", 128'({s_axis_tx_tkeep, s_axis_tx_tlast}), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_counters", 128'({tlp_count, err_count, drop_count}), 128'(0));
        chk("src_dsc", 128'(tx_src_dsc), 128'(0));
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        @(negedge user_clk);
        chk("idle_req_ready", 128'(req_ready), 128'(1));
        @(posedge user_clk);
        #1;

        // 3DW header, 1 DW payload
        exp_q.push_back('{64'h0100000F_40000001, 8'hFF, 1'b0});
        exp_q.push_back('{64'hDEADBEEF_12345678, 8'hFF, 1'b1});
        send(64'h0000_0000_1234_5678, 1'b0, 4'hF, 4'h0, 64'h0000_0000_DEAD_BEEF, -1, 1'b0);
        chk("b0_latency", 128'({s_axis_tx_tvalid, s_axis_tx_tdata}), 128'({1'b1, 64'h0100000F_40000001}));
        mtag = mtag + 8'd1;
        mtlp++;
        drain();
        chk("t1_tlp_count", 128'(tlp_count), 128'(1));

        // 4DW header, 2 DW payload
        exp_q.push_back('{64'h010001FF_60000002, 8'hFF, 1'b0});
        exp_q.push_back('{64'h00000010_00000001, 8'hFF, 1'b0});
        exp_q.push_back('{64'h11111111_22222222, 8'hFF, 1'b1});
        send(64'h0000_0001_0000_0010, 1'b1, 4'hF, 4'hF, 64'h11111111_22222222, -1, 1'b0);
        mtag = mtag + 8'd1;
        mtlp++;
        drain();
        chk("t2_tlp_count", 128'(tlp_count), 128'(2));

        // Backpressure for five cycles while B1 is presented
        send(64'h0000_0000_1234_5678, 1'b0, 4'hF, 4'h0, 64'h0000_0000_DEAD_BEEF, -1, 1'b1);
        @(posedge user_clk);
        #1;
        s_axis_tx_tready = 1'b0;
        repeat (5) @(posedge user_clk);
        #1;
        s_axis_tx_tready = 1'b1;
        drain();
        chk("t3_tlp_count", 128'(tlp_count), 128'(3));

        // 4 KB crossing is consumed without a TLP; the following TLP reuses the tag
        send(64'h0000_0000_0000_0FFC, 1'b1, 4'hF, 4'hF, 64'h0, -1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge user_clk);
            chk("t4_no_tvalid", 128'(s_axis_tx_tvalid), 128'(0));
        end
        chk("t4_err_count", 128'(err_count), 128'(1));
        @(posedge user_clk);
        #1;
        send(64'h0000_0000_0000_2040, 1'b0, 4'h3, 4'h0, 64'h0000_0000_CAFE_F00D, -1, 1'b1);
        drain();

        // Link drop while B1 is presented; a request during link-down waits
        send(64'h0000_0000_0000_3000, 1'b1, 4'hF, 4'hF, 64'hAAAA5555_12121212, 1, 1'b1);
        @(posedge user_clk);
        #1;
        s_axis_tx_tready = 1'b0;
        user_lnk_up      = 1'b0;
        mdrop++;
        @(posedge user_clk);
        @(negedge user_clk);
        chk("t5_tvalid_low", 128'({s_axis_tx_tvalid, s_axis_tx_tlast}), 128'(0));
        chk("t5_drop_count", 128'(drop_count), 128'(mdrop));
        chk("t5_tlp_count", 128'(tlp_count), 128'(mtlp));
        @(posedge user_clk);
        #1;
        drive_req(64'h0000_0000_0000_4008, 1'b0, 4'hC, 4'h0, 64'h0000_0000_0BAD_F00D);
        for (int c = 0; c < 3; c++) begin
            @(negedge user_clk);
            chk("t5_no_ready", 128'({req_ready, s_axis_tx_tvalid}), 128'(0));
        end
        @(posedge user_clk);
        #1;
        user_lnk_up      = 1'b1;
        s_axis_tx_tready = 1'b1;
        wait_accept(ok);
        if (ok) model_push(64'h0000_0000_0000_4008, 1'b0, 4'hC, 4'h0, 64'h0000_0000_0BAD_F00D, -1);
        drain();
        chk("t5_tlp_after", 128'({tlp_count, err_count, drop_count}), 128'({32'(mtlp), 32'(merr), 32'(mdrop)}));

        // Reset in the middle of a TLP
        s_axis_tx_tready = 1'b0;
        send(64'h0000_0000_0000_5000, 1'b1, 4'hF, 4'hF, 64'h1, 0, 1'b1);
        @(posedge user_clk);
        #1;
        user_reset = 1'b1;
        @(posedge user_clk);
        @(negedge user_clk);
        chk("mid_rst_tvalid", 128'(s_axis_tx_tvalid), 128'(0));
        chk("mid_rst_counters", 128'({tlp_count, err_count, drop_count}), 128'(0));
        @(posedge user_clk);
        #1;
        user_reset       = 1'b0;
        s_axis_tx_tready = 1'b1;
        mtag = 8'h00;
        mtlp = 0;
        merr = 0;
        mdrop = 0;
        @(negedge user_clk);
        chk("post_rst_idle", 128'({s_axis_tx_tvalid, req_ready}), 128'({1'b0, 1'b1}));
        @(posedge user_clk);
        #1;

        // Tag wrap: 256 back-to-back 1 DW writes, then one more with tag 00
        for (int i = 0; i < 257; i++) begin
            hi = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'h0;
            lo = 32'($urandom);
            send({hi, lo}, 1'b0, 4'($urandom), 4'($urandom), {32'h0, 32'($urandom)}, -1, 1'b1);
            if (i == 255) begin
                drain();
                chk("wrap_tlp_count", 128'(tlp_count), 128'(256));
            end
        end
        drain();

        // Random mix with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            hi = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'h0;
            lo = 32'($urandom);
            if ($urandom_range(0, 4) == 0) lo[11:2] = 10'h3FF;
            send({hi, lo}, 1'($urandom), 4'($urandom), 4'($urandom),
                 {32'($urandom), 32'($urandom)}, -1, 1'b1);
        end
        drain();
        rand_bp = 1'b0;
        @(posedge user_clk);
        #2;
        s_axis_tx_tready = 1'b1;
        chk("rand_counters", 128'({tlp_count, err_count, drop_count}),
            128'({32'(mtlp), 32'(merr), 32'(mdrop)}));
        chk("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
